epc_word_rx: RTL and testbench

Tag-side receive deserializer for EPC write payloads. It collects the serial bit stream that the command decoder extracts from a reader Write frame and assembles it into 16-bit words, MSB first. Completed words go into a small FIFO, which feeds the memory interface's EPC write path through a ready/ack handshake. It is the inbound counterpart of the memory interface's word-to-bit transmit serializer.

---
 rtl/tag_pkg.sv | 24 ++
 rtl/word_fifo.sv | 47 ++++
 rtl/epc_word_rx.sv | 162 ++++++++++++++++
 tb/tb_epc_word_rx.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tag_pkg.sv
// Shared types and constants for the tag-side EPC receive path.
// Holds the receive state encoding and the CRC-16/CCITT helpers.
package tag_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DRAIN = 2'd2
    } rx_state_e;

    localparam logic [15:0] CRC16_POLY    = 16'h1021;
    localparam logic [15:0] CRC16_PRESET  = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUE = 16'h1D0F;

    function automatic logic [15:0] crc16_upd(
        input logic [15:0] crc,
        input logic        b
    );
        logic fb;
        fb = crc[15] ^ b;
        crc16_upd = {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/word_fifo.sv
// Synchronous FIFO with extra pointer MSB for full/empty disambiguation.
// Head reads as zero while empty.
module word_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    // A pop in the same cycle frees the slot a full push needs
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + {{AW{1'b0}}, 1'b1};
            if (do_pop)  rptr_q <= rptr_q + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/epc_word_rx.sv
// EPC write-payload deserializer: serial bits to 16-bit words into a FIFO.
// Optional CRC-16 residue check is built when CRC16_CHECK_EN is defined.
module epc_word_rx
    import tag_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int MAX_WORDS = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        bit_in,
    input  logic        bit_valid,
    input  logic        packetcomplete,
    input  logic [7:0]  num_words,
    output logic [15:0] word_out,
    output logic        word_ready,
    input  logic        word_ack,
    output logic [7:0]  words_rcvd,
    output logic        overflow,
    output logic        frame_error,
    output logic        frame_done,
    output logic        crc_ok
);

    rx_state_e   state_q;
    logic [14:0] shreg_q;
    logic [3:0]  bit_cnt_q;
    logic [7:0]  nwords_q;
    logic [7:0]  words_q;
    logic        ovf_q;
    logic        ferr_q;
    logic        done_q;

    logic        fifo_full;
    logic        fifo_empty;
    logic        pop;
    logic        start;
    logic        in_shift;
    logic        at_limit;
    logic        take;
    logic        discard;
    logic        wdone;
    logic        drop;
    logic        pc_end;
    logic        crc_bad;
    logic [15:0] word_d;
    logic [3:0]  cnt_n;
    logic [3:0]  cnt_after;
    logic [7:0]  words_n;

    assign in_shift  = (state_q == SHIFT);
    assign start     = (state_q == IDLE) && bit_valid;
    assign at_limit  = (words_q == nwords_q) ||
                       (int'(words_q) >= MAX_WORDS);
    assign take      = in_shift && bit_valid && !at_limit;
    assign discard   = in_shift && bit_valid && at_limit;
    assign cnt_n     = bit_cnt_q + 4'd1;
    assign cnt_after = take ? cnt_n : bit_cnt_q;
    assign wdone     = take && (bit_cnt_q == 4'hF);
    assign words_n   = wdone ? words_q + 8'd1 : words_q;
    assign word_d    = {shreg_q, bit_in};
    assign pop       = word_ack && !fifo_empty;
    assign drop      = wdone && fifo_full && !pop;
    assign pc_end    = in_shift && packetcomplete;

    word_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (wdone),
        .data_i  (word_d),
        .pop_i   (pop),
        .data_o  (word_out),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

`ifdef CRC16_CHECK_EN
    logic [15:0] crc_q;
    logic [15:0] crc_n;
    logic        crc_ok_q;

    assign crc_n   = (start || take) ? crc16_upd(crc_q, bit_in) : crc_q;
    assign crc_bad = (crc_n != CRC16_RESIDUE);
    assign crc_ok  = crc_ok_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            crc_q    <= CRC16_PRESET;
            crc_ok_q <= 1'b1;
        end else if (pc_end) begin
            crc_q    <= CRC16_PRESET;
            crc_ok_q <= !crc_bad;
        end else begin
            crc_q    <= crc_n;
        end
    end
`else
    assign crc_bad = 1'b0;
    assign crc_ok  = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            nwords_q  <= '0;
            words_q   <= '0;
            ovf_q     <= 1'b0;
            ferr_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bit_valid) begin
                        nwords_q  <= num_words;
                        words_q   <= '0;
                        ovf_q     <= 1'b0;
                        ferr_q    <= 1'b0;
                        shreg_q   <= {14'd0, bit_in};
                        bit_cnt_q <= 4'd1;
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (take) begin
                        shreg_q   <= word_d[14:0];
                        bit_cnt_q <= cnt_n;
                    end
                    words_q <= words_n;
                    if (drop)    ovf_q  <= 1'b1;
                    if (discard) ferr_q <= 1'b1;
                    // Bit of this cycle is folded in before the end-of-frame checks
                    if (packetcomplete) begin
                        if (cnt_after != 4'd0 || words_n != nwords_q || crc_bad)
                            ferr_q <= 1'b1;
                        bit_cnt_q <= '0;
                        state_q   <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (fifo_empty) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign word_ready  = !fifo_empty;
    assign words_rcvd  = words_q;
    assign overflow    = ovf_q;
    assign frame_error = ferr_q;
    assign frame_done  = done_q;

endmodule

// File: tb/tb_epc_word_rx.sv
// Scoreboard bench for epc_word_rx: random and directed frames vs a frame-level model.
// Expectations follow CRC16_CHECK_EN when the bench is built with it.
module tb_epc_word_rx;

    localparam int DEPTH     = 4;
    localparam int MAX_WORDS = 32;
    localparam int NEVER     = 1 << 20;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        bit_in = 1'b0;
    logic        bit_valid = 1'b0;
    logic        packetcomplete = 1'b0;
    logic [7:0]  num_words = 8'd0;
    logic [15:0] word_out;
    logic        word_ready;
    logic        word_ack = 1'b0;
    logic [7:0]  words_rcvd;
    logic        overflow;
    logic        frame_error;
    logic        frame_done;
    logic        crc_ok;

    typedef struct {
        logic [7:0] wr;
        logic       ovf;
        logic       ferr;
        logic       cok;
    } frm_t;

    logic [15:0] exp_q [$];
    frm_t        frm_q [$];
    bit          fb [$];
    int          nchk = 0;
    int          nerr = 0;
    int          ndone = 0;

    epc_word_rx #(
        .DEPTH     (DEPTH),
        .MAX_WORDS (MAX_WORDS)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .bit_in         (bit_in),
        .bit_valid      (bit_valid),
        .packetcomplete (packetcomplete),
        .num_words      (num_words),
        .word_out       (word_out),
        .word_ready     (word_ready),
        .word_ack       (word_ack),
        .words_rcvd     (words_rcvd),
        .overflow       (overflow),
        .frame_error    (frame_error),
        .frame_done     (frame_done),
        .crc_ok         (crc_ok)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        nchk++;
        nerr++;
        $display("FAIL %s", nm);
    endtask

    // CCITT polynomial division, MSB first, register preset to all ones
    function automatic logic [15:0] crc_bits(input int from, input int cnt);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = from; i < from + cnt; i++) begin
            if (c[15] ^ fb[i]) c = (c << 1) ^ 16'h1021;
            else               c = c << 1;
        end
        return c;
    endfunction

    task automatic add_word(input logic [15:0] w);
        for (int b = 15; b >= 0; b--) fb.push_back(w[b]);
    endtask

    function automatic logic [15:0] word_at(input int j);
        logic [15:0] w;
        w = '0;
        for (int b = 0; b < 16; b++) w = {w[14:0], logic'(fb[16*j+b])};
        return w;
    endfunction

    // Frame-level expectations: words seen, drops before consumer starts, flags
    task automatic model_frame(input int n, input int k, output int a);
        int   wl, nw, pre;
        frm_t f;
        wl  = (n < MAX_WORDS) ? n : MAX_WORDS;
        a   = (fb.size() < 16*wl) ? fb.size() : 16*wl;
        nw  = a / 16;
        pre = (k / 16 < nw) ? k / 16 : nw;
        f.ferr = (fb.size() > 16*wl) || (a % 16 != 0) || (nw != n);
        f.ovf  = (pre > DEPTH);
        f.wr   = 8'(nw);
        for (int j = 0; j < nw; j++)
            if (!(j < pre && j >= DEPTH)) exp_q.push_back(word_at(j));
`ifdef CRC16_CHECK_EN
        f.cok = (crc_bits(0, a) == 16'h1D0F);
`else
        f.cok = 1'b1;
`endif
        if (!f.cok) f.ferr = 1'b1;
        frm_q.push_back(f);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int n, input int k, input int gapmax,
                             input bit pc_same);
        int a, tgt, t;
        model_frame(n, k, a);
        num_words = 8'(n);
        word_ack  = (k == 0);
        for (int i = 0; i < fb.size(); i++) begin
            repeat ($urandom_range(0, gapmax)) tick();
            bit_in    = fb[i];
            bit_valid = 1'b1;
            if (i == k) word_ack = 1'b1;
            if (pc_same && i == fb.size() - 1) packetcomplete = 1'b1;
            tick();
            bit_valid      = 1'b0;
            packetcomplete = 1'b0;
            if (i == 0) num_words = 8'($urandom_range(0, 255));
            if (k == 0 && i % 16 == 15 && i < a) begin
                chk("lat_ready", word_ready, 1'b1);
                chk("lat_word", word_out, word_at(i / 16));
            end
        end
        if (!pc_same) begin
            packetcomplete = 1'b1;
            tick();
            packetcomplete = 1'b0;
        end
        word_ack = 1'b1;
        tgt = ndone + 1;
        t   = 0;
        while (ndone < tgt && t < 2000) begin
            tick();
            t++;
        end
        if (ndone < tgt) fail("frame_done_timeout");
        fb.delete();
        tick();
    endtask

    always @(negedge clk) begin
        if (word_ready && word_ack) begin
            if (exp_q.size() == 0) fail("unexpected_word");
            else chk("word_out", word_out, exp_q.pop_front());
        end
        if (frame_done) begin
            if (frm_q.size() == 0) begin
                fail("unexpected_frame_done");
            end else begin
                frm_t f;
                f = frm_q.pop_front();
                chk("words_rcvd", words_rcvd, f.wr);
                chk("overflow", overflow, f.ovf);
                chk("frame_error", frame_error, f.ferr);
                chk("crc_ok", crc_ok, f.cok);
                chk("words_left", exp_q.size(), 0);
            end
            ndone++;
        end
    end

    initial begin
        logic [15:0] c;
        int n, l, k, r;

        repeat (3) tick();
        chk("rst_word_out", word_out, 16'h0);
        chk("rst_word_ready", word_ready, 1'b0);
        chk("rst_words_rcvd", words_rcvd, 8'h0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_frame_error", frame_error, 1'b0);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_crc_ok", crc_ok, 1'b1);
        reset_n = 1'b1;
        tick();

        add_word(16'hA5C3);
        add_word(16'h1234);
        run_frame(2, 0, 0, 1'b0);

        for (int i = 0; i < 6; i++) add_word(16'($urandom));
        run_frame(6, NEVER, 0, 1'b0);

        for (int i = 0; i < 20; i++) fb.push_back(1'($urandom));
        run_frame(2, 0, 0, 1'b0);

        add_word(16'h3000);
        c = crc_bits(0, 16);
        add_word(~c);
        run_frame(2, 0, 1, 1'b0);

        add_word(16'h3008);
        add_word(~c);
        run_frame(2, 0, 1, 1'b0);

        for (int i = 0; i < 8; i++) begin
            bit_in    = 1'($urandom);
            bit_valid = 1'b1;
            tick();
        end
        bit_valid = 1'b0;
        reset_n   = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("midrst_ready", word_ready, 1'b0);
        chk("midrst_words", words_rcvd, 8'h0);
        repeat (20) tick();
        add_word(16'hBEEF);
        run_frame(1, 0, 0, 1'b0);

        for (int i = 0; i < DEPTH + 1; i++) add_word(16'($urandom));
        run_frame(DEPTH + 1, 16*(DEPTH+1) - 1, 0, 1'b0);

        for (int i = 0; i < MAX_WORDS + 2; i++) add_word(16'($urandom));
        run_frame(MAX_WORDS + 2, 0, 0, 1'b1);

        for (int i = 0; i < 20; i++) fb.push_back(1'($urandom));
        run_frame(1, 0, 0, 1'b0);

        for (int f = 0; f < 12; f++) begin
            n = $urandom_range(1, 6);
            r = $urandom_range(0, 2);
            l = 16*n;
            if (r == 1) l = l - $urandom_range(1, 15);
            if (r == 2) l = l + $urandom_range(1, 20);
            for (int i = 0; i < l; i++) fb.push_back(1'($urandom));
            r = $urandom_range(0, 2);
            k = (r == 0) ? 0 : (r == 1) ? NEVER : $urandom_range(0, l - 1);
            run_frame(n, k, $urandom_range(0, 2), 1'($urandom));
        end

        repeat (5) tick();
        chk("final_words_left", exp_q.size(), 0);
        chk("final_frames_left", frm_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
